// File: rtl/mod_updown_cntr_if.sv
// Control/status bundle between a controller FSM and mod_updown_cntr.
// Clock and hard reset stay plain ports on the counter.
interface mod_updown_cntr_if #(
    parameter int unsigned WIDTH = 4
);
    logic             soft_rst;
    logic             en;
    logic             incr;
    logic             decr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] cnt_out;
    logic             tc_pulse;
    logic             ovf_flag;
    logic             at_max;
    logic             at_zero;

    modport master (
        output soft_rst, en, incr, decr, load, load_val,
        input  cnt_out, tc_pulse, ovf_flag, at_max, at_zero
    );

    modport slave (
        input  soft_rst, en, incr, decr, load, load_val,
        output cnt_out, tc_pulse, ovf_flag, at_max, at_zero
    );
endinterface

// File: rtl/mod_updown_cntr.sv
// Modulo-N up/down counter with parallel load, wrap/saturate boundary mode,
// registered terminal-event pulse and sticky overflow flag.
module mod_updown_cntr #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MOD_VAL  = 10,
    parameter bit          SAT_MODE = 1'b0
) (
    input  logic                 clk,
    input  logic                 hard_rst_n,
    mod_updown_cntr_if.slave     bus
);
    // MOD_VAL may equal 2**WIDTH, so the range check is done in 64 bits
    localparam longint unsigned RANGE = 64'(1) << WIDTH;

    generate
        if (MOD_VAL < 2 || 64'(MOD_VAL) > RANGE) begin : g_bad_mod
            $error("mod_updown_cntr: MOD_VAL out of range for WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD_VAL - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             step_up, step_dn;

    // incr and decr together cancel out; en gates stepping only
    assign step_up = bus.en & bus.incr & ~bus.decr;
    assign step_dn = bus.en & bus.decr & ~bus.incr;

    // Next-state: soft_rst > load > step > hold
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q;
        if (bus.soft_rst) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (bus.load) begin
            cnt_d = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
        end else if (step_up) begin
            if (cnt_q == MAX_V) begin
                tc_d  = 1'b1;
                ovf_d = 1'b1;
                if (!SAT_MODE) cnt_d = '0;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end else if (step_dn) begin
            if (cnt_q == '0) begin
                tc_d  = 1'b1;
                ovf_d = 1'b1;
                if (!SAT_MODE) cnt_d = MAX_V;
            end else begin
                cnt_d = cnt_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge hard_rst_n) begin
        if (!hard_rst_n) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.cnt_out  = cnt_q;
    assign bus.tc_pulse = tc_q;
    assign bus.ovf_flag = ovf_q;
    assign bus.at_max   = (cnt_q == MAX_V);
    assign bus.at_zero  = (cnt_q == '0);
endmodule

// File: tb/tb_mod_updown_cntr.sv
// Directed bench for mod_updown_cntr: wrap (4/10), saturate (4/10) and
// full-range (4/16) instances driven one at a time.
module tb_mod_updown_cntr;
    logic clk;
    logic hard_rst_n;
    int   n_tests;
    int   n_fail;

    mod_updown_cntr_if #(.WIDTH(4)) w_if ();
    mod_updown_cntr_if #(.WIDTH(4)) s_if ();
    mod_updown_cntr_if #(.WIDTH(4)) f_if ();

    mod_updown_cntr #(.WIDTH(4), .MOD_VAL(10), .SAT_MODE(1'b0)) u_wrap (
        .clk(clk), .hard_rst_n(hard_rst_n), .bus(w_if.slave));
    mod_updown_cntr #(.WIDTH(4), .MOD_VAL(10), .SAT_MODE(1'b1)) u_sat (
        .clk(clk), .hard_rst_n(hard_rst_n), .bus(s_if.slave));
    mod_updown_cntr #(.WIDTH(4), .MOD_VAL(16), .SAT_MODE(1'b0)) u_full (
        .clk(clk), .hard_rst_n(hard_rst_n), .bus(f_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_w(input string tag, input int c, input int tc, input int ovf);
        check({tag, ".cnt"}, 32'(w_if.cnt_out),  32'(c));
        check({tag, ".tc"},  32'(w_if.tc_pulse), 32'(tc));
        check({tag, ".ovf"}, 32'(w_if.ovf_flag), 32'(ovf));
    endtask

    task automatic chk_s(input string tag, input int c, input int tc, input int ovf);
        check({tag, ".cnt"}, 32'(s_if.cnt_out),  32'(c));
        check({tag, ".tc"},  32'(s_if.tc_pulse), 32'(tc));
        check({tag, ".ovf"}, 32'(s_if.ovf_flag), 32'(ovf));
    endtask

    task automatic chk_f(input string tag, input int c, input int tc, input int ovf);
        check({tag, ".cnt"}, 32'(f_if.cnt_out),  32'(c));
        check({tag, ".tc"},  32'(f_if.tc_pulse), 32'(tc));
        check({tag, ".ovf"}, 32'(f_if.ovf_flag), 32'(ovf));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        hard_rst_n = 1'b0;
        {w_if.soft_rst, w_if.en, w_if.incr, w_if.decr, w_if.load} = '0;
        {s_if.soft_rst, s_if.en, s_if.incr, s_if.decr, s_if.load} = '0;
        {f_if.soft_rst, f_if.en, f_if.incr, f_if.decr, f_if.load} = '0;
        w_if.load_val = '0;
        s_if.load_val = '0;
        f_if.load_val = '0;

        tick();
        tick();
        chk_w("rst_w", 0, 0, 0);
        chk_s("rst_s", 0, 0, 0);
        chk_f("rst_f", 0, 0, 0);
        check("rst_w.at_zero", 32'(w_if.at_zero), 32'd1);
        check("rst_w.at_max",  32'(w_if.at_max),  32'd0);
        hard_rst_n = 1'b1;

        // Wrap up: 1..9, 0, 1, 2
        w_if.en = 1'b1; w_if.incr = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk_w($sformatf("wrap_up%0d", i), i % 10, (i == 10) ? 1 : 0, (i >= 10) ? 1 : 0);
            check($sformatf("wrap_up%0d.at_max", i), 32'(w_if.at_max), ((i % 10) == 9) ? 32'd1 : 32'd0);
        end
        w_if.incr = 1'b0;
        tick();
        chk_w("hold_after_up", 2, 0, 1);

        // soft_rst clears count and sticky flag
        w_if.soft_rst = 1'b1;
        tick();
        chk_w("soft_rst", 0, 0, 0);
        w_if.soft_rst = 1'b0;

        // Wrap down from 0
        w_if.decr = 1'b1;
        tick();
        chk_w("wrap_dn", 9, 1, 1);
        check("wrap_dn.at_max", 32'(w_if.at_max), 32'd1);
        w_if.decr = 1'b0;
        tick();
        chk_w("wrap_dn_hold", 9, 0, 1);

        // Load clamp beats a terminal-condition incr
        w_if.load = 1'b1; w_if.load_val = 4'd13; w_if.incr = 1'b1;
        tick();
        chk_w("load_clamp", 9, 0, 1);
        // soft_rst beats load
        w_if.incr = 1'b0; w_if.load_val = 4'd5; w_if.soft_rst = 1'b1;
        tick();
        chk_w("srst_over_load", 0, 0, 0);
        w_if.soft_rst = 1'b0;

        // Holds at 4
        w_if.load_val = 4'd4;
        tick();
        chk_w("load4", 4, 0, 0);
        w_if.load = 1'b0; w_if.incr = 1'b1; w_if.decr = 1'b1;
        tick();
        chk_w("hold_both", 4, 0, 0);
        w_if.decr = 1'b0; w_if.en = 1'b0;
        tick();
        chk_w("hold_en0", 4, 0, 0);
        w_if.incr = 1'b0; w_if.en = 1'b1; w_if.decr = 1'b1;
        tick();
        chk_w("dn_step", 3, 0, 0);
        w_if.decr = 1'b0;

        // soft_rst suppresses a terminal step at MAX
        w_if.load = 1'b1; w_if.load_val = 4'd9;
        tick();
        w_if.load = 1'b0; w_if.incr = 1'b1; w_if.soft_rst = 1'b1;
        tick();
        chk_w("srst_over_tc", 0, 0, 0);
        w_if.soft_rst = 1'b0; w_if.incr = 1'b0;

        // Reach 7 with ovf set, then async reset between edges
        w_if.load = 1'b1; w_if.load_val = 4'd9;
        tick();
        w_if.load = 1'b0; w_if.incr = 1'b1;
        tick();
        chk_w("pre_async_wrap", 0, 1, 1);
        w_if.incr = 1'b0; w_if.load = 1'b1; w_if.load_val = 4'd7;
        tick();
        chk_w("pre_async_7", 7, 0, 1);
        w_if.load = 1'b0;
        #2;
        hard_rst_n = 1'b0;
        #1;
        chk_w("async_rst", 0, 0, 0);
        w_if.incr = 1'b1;
        #1;
        hard_rst_n = 1'b1;
        tick();
        chk_w("async_resume", 1, 0, 0);
        w_if.incr = 1'b0; w_if.en = 1'b0;

        // Saturate: held decr at 0 pulses every cycle
        s_if.en = 1'b1; s_if.decr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_s($sformatf("sat_dn%0d", i), 0, 1, 1);
        end
        s_if.decr = 1'b0;
        tick();
        chk_s("sat_dn_release", 0, 0, 1);
        s_if.load = 1'b1; s_if.load_val = 4'd8;
        tick();
        s_if.load = 1'b0; s_if.incr = 1'b1;
        tick();
        chk_s("sat_up9", 9, 0, 1);
        tick();
        chk_s("sat_up_hold1", 9, 1, 1);
        tick();
        chk_s("sat_up_hold2", 9, 1, 1);
        s_if.incr = 1'b0; s_if.decr = 1'b1;
        tick();
        chk_s("sat_dn8", 8, 0, 1);
        s_if.decr = 1'b0; s_if.en = 1'b0;

        // Full range 0..15
        f_if.load = 1'b1; f_if.load_val = 4'd15;
        tick();
        chk_f("full_load15", 15, 0, 0);
        check("full.at_max", 32'(f_if.at_max), 32'd1);
        f_if.load = 1'b0; f_if.en = 1'b1; f_if.incr = 1'b1;
        tick();
        chk_f("full_wrap_up", 0, 1, 1);
        check("full.at_zero", 32'(f_if.at_zero), 32'd1);
        f_if.incr = 1'b0; f_if.decr = 1'b1;
        tick();
        chk_f("full_wrap_dn", 15, 1, 1);
        f_if.decr = 1'b0;
        tick();
        chk_f("full_hold", 15, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
